// File: rtl/sha_nonce_scheduler.sv
// Nonce-sweep sequencer for a single SHA-256 core: runs SHA(SHA(header)) per nonce,
// compares the second digest against a target and stops on a hit, range end or core timeout.
module sha_nonce_scheduler #(
    parameter int MSG_W       = 1976,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [639:0]     header_in,
    input  logic [31:0]      nonce_start,
    input  logic [31:0]      nonce_end,
    input  logic [255:0]     target,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic             timeout_err,
    output logic [31:0]      result_nonce,
    output logic [255:0]     result_hash,
    output logic [31:0]      hash_count,
    output logic [MSG_W-1:0] sha_msg,
    output logic             sha_begin,
    input  logic             sha_done,
    input  logic [255:0]     sha_hash
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD1 = 3'd1,
        WAIT1 = 3'd2,
        LOAD2 = 3'd3,
        WAIT2 = 3'd4,
        CMP   = 3'd5,
        DONE  = 3'd6
    } state_e;

    state_e          stateReg;
    state_e          stateNext;
    logic [607:0]    headerReg;
    logic [31:0]     nonceReg;
    logic [31:0]     nonceEndReg;
    logic [255:0]    targetReg;
    logic [255:0]    midReg;
    logic [WD_W-1:0] wdCountReg;
    logic            foundReg;
    logic            timeoutErrReg;
    logic [31:0]     resultNonceReg;
    logic [255:0]    resultHashReg;
    logic [31:0]     hashCountReg;

    logic inWait;
    logic wdExpired;
    logic hit;
    logic lastNonce;
    logic unusedHeaderBits;

    // The header's own nonce field is replaced by the sweep counter.
    assign unusedHeaderBits = ^header_in[31:0];

    assign inWait    = (stateReg == WAIT1) || (stateReg == WAIT2);
    assign wdExpired = (wdCountReg == WD_W'(TIMEOUT_CYC - 1));
    assign hit       = (resultHashReg < targetReg);
    assign lastNonce = (nonceReg == nonceEndReg);

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (start) stateNext = LOAD1;
            LOAD1:   stateNext = WAIT1;
            WAIT1: begin
                if (sha_done)       stateNext = LOAD2;
                else if (wdExpired) stateNext = DONE;
            end
            LOAD2:   stateNext = WAIT2;
            WAIT2: begin
                if (sha_done)       stateNext = CMP;
                else if (wdExpired) stateNext = DONE;
            end
            CMP: begin
                if (hit || lastNonce) stateNext = DONE;
                else                  stateNext = LOAD1;
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (abort) stateNext = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg       <= IDLE;
            headerReg      <= '0;
            nonceReg       <= '0;
            nonceEndReg    <= '0;
            targetReg      <= '0;
            midReg         <= '0;
            wdCountReg     <= '0;
            foundReg       <= 1'b0;
            timeoutErrReg  <= 1'b0;
            resultNonceReg <= '0;
            resultHashReg  <= '0;
            hashCountReg   <= '0;
        end else begin
            stateReg <= stateNext;
            // Abort freezes the datapath so a coincident sha_done cannot update results.
            if (!abort) begin
                case (stateReg)
                    IDLE: begin
                        if (start) begin
                            headerReg     <= header_in[639:32];
                            nonceReg      <= nonce_start;
                            nonceEndReg   <= nonce_end;
                            targetReg     <= target;
                            foundReg      <= 1'b0;
                            timeoutErrReg <= 1'b0;
                            hashCountReg  <= '0;
                        end
                    end
                    LOAD1, LOAD2: wdCountReg <= '0;
                    WAIT1: begin
                        wdCountReg <= wdCountReg + 1'b1;
                        if (sha_done)       midReg        <= sha_hash;
                        else if (wdExpired) timeoutErrReg <= 1'b1;
                    end
                    WAIT2: begin
                        wdCountReg <= wdCountReg + 1'b1;
                        if (sha_done) begin
                            resultHashReg  <= sha_hash;
                            resultNonceReg <= nonceReg;
                            hashCountReg   <= hashCountReg + 32'd1;
                        end else if (wdExpired) begin
                            timeoutErrReg <= 1'b1;
                        end
                    end
                    CMP: begin
                        if (hit)             foundReg <= 1'b1;
                        else if (!lastNonce) nonceReg <= nonceReg + 32'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy         = (stateReg != IDLE);
    assign done         = (stateReg == DONE);
    assign sha_begin    = (stateReg == LOAD1) || (stateReg == LOAD2);
    assign found        = foundReg;
    assign timeout_err  = timeoutErrReg;
    assign result_nonce = resultNonceReg;
    assign result_hash  = resultHashReg;
    assign hash_count   = hashCountReg;

    // Second hash consumes the first digest; otherwise the header with the current nonce.
    assign sha_msg = ((stateReg == LOAD2) || (stateReg == WAIT2)) ? MSG_W'(midReg)
                                                                   : MSG_W'({headerReg, nonceReg});

endmodule
